// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit.
// Bit timing comes from a per-frame latched prescale, clamped to a minimum of 4.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [5:0] MIN_PRESC = 6'd4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [5:0]            presc_q, presc_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  bit_end;
    logic                  last_bit;

    assign bit_end  = (cnt_q == (presc_q - 6'd1));
    assign last_bit = (bit_q == LAST_BIT);

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = 1'b1;
        busy_d    = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                cnt_d = 6'd0;
                bit_d = '0;
                if (DATA_VALID) begin
                    shift_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                    presc_d   = (prescale < MIN_PRESC) ? MIN_PRESC : prescale;
                    state_d   = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = 6'd0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    cnt_d   = 6'd0;
                    shift_d = shift_q >> 1;
                    if (last_bit) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            PARITY: begin
                tx_d = par_bit_q;
                if (bit_end) begin
                    cnt_d   = 6'd0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Reset wins over everything, so a request on a reset cycle is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            presc_q   <= 6'd0;
            shift_q   <= '0;
            bit_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning number of data bits per frame.
REQ-002 SHALL have port CLK  input  1  oversampling clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 SHALL have port DATA_VALID  input  1  request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  1 = append parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port prescale  input  6  CLK cycles per bit period.
REQ-009 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept a request only in IDLE with DATA_VALID=1. On that edge it latches P_DATA, PAR_EN, PAR_TYP and prescale, then enters START.
REQ-013 SHALL ignore DATA_VALID in every non-IDLE state. No queueing.
REQ-014 SHALL keep the frame unaffected by changes to P_DATA, PAR_EN, PAR_TYP or prescale after acceptance.
REQ-015 SHALL treat a latched prescale value below 4 as 4. Each bit period lasts the latched prescale CLK cycles.
REQ-016 SHALL time each bit with a 6-bit edge counter:
- Counter starts at 0 on entry to each bit.
- State advances on the cycle the counter equals prescale-1; the counter then wraps to 0.
REQ-017 SHALL drive TX_OUT by state, registered:
- IDLE = 1
- START = 0
- DATA = shift-register bit, LSB first
- PARITY = parity bit
- STOP = 1
REQ-018 SHALL go from DATA to PARITY after DATA_WIDTH bits when latched PAR_EN=1, otherwise directly to STOP.
REQ-019 SHALL compute parity as the XOR of all latched data bits, inverted when latched PAR_TYP=1.
REQ-020 SHALL return from STOP to IDLE after one bit period. At least one IDLE cycle separates consecutive frames.
REQ-021 SHALL change TX_OUT to 0 on the first CLK edge after the accepting edge (latency 1 cycle).
REQ-022 SHALL assert busy from the first START cycle through the last STOP cycle. busy is low in IDLE.
REQ-023 SHALL make the frame length in CLK cycles equal to (2 + DATA_WIDTH + PAR_EN) × latched prescale.
REQ-024 SHALL have no glitches on TX_OUT: it is driven from a flop only.

Reset
REQ-025 SHALL, while RST=1 at a CLK edge, force:
- state = IDLE
- TX_OUT = 1
- busy = 0
- edge counter = 0
- shift register = 0
- latched configuration = 0
REQ-026 SHALL abort any frame in progress on reset. TX_OUT returns high on the next edge and the partial frame is not resumed.
REQ-027 SHALL NOT accept DATA_VALID on a cycle where RST=1.

Verification
REQ-028 SHALL check frame with even parity:
- Stimulus: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, prescale=8, one-cycle DATA_VALID.
- Required: TX_OUT = 0, 1,0,1,0,0,1,0,1, 0, 1, each held 8 cycles.
- Required: busy high for exactly 88 cycles.
REQ-029 SHALL check odd parity:
- Stimulus: same as REQ-028 but PAR_TYP=1.
- Required: parity slot = 1.
REQ-030 SHALL check frame without parity:
- Stimulus: P_DATA=0x00, PAR_EN=0, prescale=16.
- Required: TX_OUT low for 144 cycles, then high for 16 cycles.
- Required: busy high for 160 cycles, then low.
REQ-031 SHALL check that requests during a frame are ignored:
- Stimulus: DATA_VALID held high with P_DATA changing every cycle during a frame.
- Required: only the byte accepted first is transmitted.
- Required: the next frame starts only after busy falls and one IDLE cycle passes.
REQ-032 SHALL check reset mid-frame:
- Stimulus: RST=1 for one cycle during the 4th data bit.
- Required: next cycle TX_OUT=1 and busy=0.
- Required: a new DATA_VALID then produces a complete, correct frame.
REQ-033 SHALL check prescale edge cases:
- Stimulus: prescale=2 at acceptance.
- Required: every bit lasts 4 cycles.
- Stimulus: prescale changed from 8 to 32 mid-frame.
- Required: the remaining bits still last 8 cycles.
